// File: rtl/calc_keys_pkg.sv
// Shared key-grid definitions for the on-screen 3x9 calculator keypad.
// The cursor navigator, the border highlighter and the calculator core all use
// these helpers, so they agree on the cell-to-key mapping.
package calc_keys_pkg;

  localparam int ROWS     = 3;
  localparam int COLS     = 9;
  localparam int ORIGIN_X = 10;  // screen X of column 0
  localparam int ORIGIN_Y = 6;   // screen Y of row 0
  localparam int KEY_W    = 26;  // width of the one-hot key strobe

  typedef logic [1:0] row_t;
  typedef logic [3:0] col_t;
  typedef logic [4:0] pos_t;
  typedef logic [4:0] key_idx_t;

  // The only grid cell that holds no key.
  localparam row_t EMPTY_ROW = 2'd0;
  localparam col_t EMPTY_COL = 4'd8;
  localparam pos_t POS_NONE  = 5'd31;

  typedef enum logic [1:0] {
    NAV_IDLE,
    NAV_FIRE,
    NAV_HOLD
  } nav_state_e;

  // Position code drawn by the border highlighter for a grid cell.
  function automatic pos_t key_pos(input row_t r, input col_t c);
    pos_t p;
    p = POS_NONE;
    case ({r, c})
      {2'd0, 4'd0}: p = 5'd20;
      {2'd0, 4'd1}: p = 5'd21;
      {2'd0, 4'd2}: p = 5'd22;
      {2'd0, 4'd3}: p = 5'd23;
      {2'd0, 4'd4}: p = 5'd15;
      {2'd0, 4'd5}: p = 5'd16;
      {2'd0, 4'd6}: p = 5'd17;
      {2'd0, 4'd7}: p = 5'd18;
      {2'd1, 4'd0}: p = 5'd10;
      {2'd1, 4'd1}: p = 5'd11;
      {2'd1, 4'd2}: p = 5'd12;
      {2'd1, 4'd3}: p = 5'd13;
      {2'd1, 4'd4}: p = 5'd5;
      {2'd1, 4'd5}: p = 5'd6;
      {2'd1, 4'd6}: p = 5'd7;
      {2'd1, 4'd7}: p = 5'd8;
      {2'd1, 4'd8}: p = 5'd4;
      {2'd2, 4'd0}: p = 5'd25;
      {2'd2, 4'd1}: p = 5'd9;
      {2'd2, 4'd2}: p = 5'd2;
      {2'd2, 4'd3}: p = 5'd3;
      {2'd2, 4'd4}: p = 5'd0;
      {2'd2, 4'd5}: p = 5'd1;
      {2'd2, 4'd6}: p = 5'd19;
      {2'd2, 4'd7}: p = 5'd14;
      {2'd2, 4'd8}: p = 5'd24;
      default:      p = POS_NONE;
    endcase
    return p;
  endfunction

  // Bit index of the one-hot key strobe for a grid cell. Row 0 and the first
  // eight cells of row 1 are packed in order; row 2 follows from bit 16 and
  // the lone ninth key of row 1 sits at the top, bit 25.
  function automatic key_idx_t key_index(input row_t r, input col_t c);
    key_idx_t idx;
    idx = '0;
    if (r == EMPTY_ROW && c == EMPTY_COL) begin
      idx = '0;  // no key here; the cursor never rests on this cell
    end else begin
      case (r)
        2'd0:    idx = {1'b0, c};
        2'd1:    idx = (c == EMPTY_COL) ? 5'd25 : 5'd8 + {1'b0, c};
        default: idx = 5'd16 + {1'b0, c};
      endcase
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: two-flop synchronizer, stability counter and
// registered rising-edge detector on the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press_q;

  // Count consecutive disagreeing samples; flip the level once they persist.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer, debounce state and edge detector registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each flop sample the pre-edge
      // value of its neighbour, which is what makes the synchronizer a chain.
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/keypad_cursor_nav.sv
// Five-button cursor navigator for the 3x9 calculator key grid. Moves the
// highlight frame on U/D/L/R presses and strobes the selected key on C.
module keypad_cursor_nav
  import calc_keys_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BTN_U,
  input  logic              BTN_D,
  input  logic              BTN_L,
  input  logic              BTN_R,
  input  logic              BTN_C,
  output logic [4:0]        POS,
  output logic [1:0]        ROW,
  output logic [3:0]        COL,
  output logic [KEY_W-1:0]  KEY,
  output logic              BUSY
);

  localparam int BI_U = 0;
  localparam int BI_D = 1;
  localparam int BI_L = 2;
  localparam int BI_R = 3;
  localparam int BI_C = 4;

  logic [4:0] btn_raw, lvl, press;
  logic       unused_levels;

  assign btn_raw = {BTN_C, BTN_R, BTN_L, BTN_D, BTN_U};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[i]),
      .level(lvl[i]),
      .press(press[i])
    );
  end

  // Only the centre button's held level matters (it gates leaving HOLD).
  assign unused_levels = ^lvl[BI_R:BI_U];

  // Row 0 has one cell fewer, so its horizontal wrap point is column 7.
  function automatic col_t last_col(input row_t r);
    return (r == EMPTY_ROW) ? col_t'(COLS - 2) : col_t'(COLS - 1);
  endfunction

  function automatic col_t move_left(input row_t r, input col_t c);
    return (c == '0) ? last_col(r) : c - 1'b1;
  endfunction

  function automatic col_t move_right(input row_t r, input col_t c);
    return (c == last_col(r)) ? '0 : c + 1'b1;
  endfunction

  // Column 8 only spans rows 1 and 2, so vertical moves there just swap them.
  function automatic row_t move_up(input row_t r, input col_t c);
    if (c == EMPTY_COL) return (r == 2'd2) ? 2'd1 : 2'd2;
    return (r == '0) ? row_t'(ROWS - 1) : r - 1'b1;
  endfunction

  function automatic row_t move_down(input row_t r, input col_t c);
    if (c == EMPTY_COL) return (r == 2'd1) ? 2'd2 : 2'd1;
    return (r == row_t'(ROWS - 1)) ? '0 : r + 1'b1;
  endfunction

  nav_state_e       state_q, state_d;
  row_t             row_q, row_d;
  col_t             col_q, col_d;
  pos_t             pos_q, pos_d;
  logic [KEY_W-1:0] key_q, key_d;

  // Next-state logic: act on the highest-priority press in IDLE only.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    key_d   = '0;
    case (state_q)
      NAV_IDLE: begin
        if (press[BI_C]) begin
          key_d   = KEY_W'(1) << key_index(row_q, col_q);
          state_d = NAV_FIRE;
        end else if (press[BI_U]) begin
          row_d = move_up(row_q, col_q);
        end else if (press[BI_D]) begin
          row_d = move_down(row_q, col_q);
        end else if (press[BI_L]) begin
          col_d = move_left(row_q, col_q);
        end else if (press[BI_R]) begin
          col_d = move_right(row_q, col_q);
        end
      end
      NAV_FIRE: state_d = NAV_HOLD;
      NAV_HOLD: if (!lvl[BI_C]) state_d = NAV_IDLE;
      default:  state_d = NAV_IDLE;
    endcase
    // Position is looked up from the next cursor so POS leaves a register.
    pos_d = key_pos(row_d, col_d);
  end

  // Cursor, strobe and state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NAV_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      pos_q   <= 5'd20;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pos_q   <= pos_d;
      key_q   <= key_d;
    end
  end

  assign ROW  = row_q;
  assign COL  = col_q;
  assign POS  = pos_q;
  assign KEY  = key_q;
  assign BUSY = (state_q != NAV_IDLE);

endmodule

// File: tb/tb_keypad_cursor_nav.sv
// Scoreboard bench for keypad_cursor_nav: stimulus queues the expected output
// tuples, a negedge monitor pops one on every change of the DUT outputs.
module tb_keypad_cursor_nav;

  localparam int DEB = 4;
  localparam int BU = 0, BD = 1, BL = 2, BR = 3, BC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btn = '0;
  logic [4:0]  POS;
  logic [1:0]  ROW;
  logic [3:0]  COL;
  logic [25:0] KEY;
  logic        BUSY;

  keypad_cursor_nav #(
    .DEB_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .BTN_U(btn[BU]),
    .BTN_D(btn[BD]),
    .BTN_L(btn[BL]),
    .BTN_R(btn[BR]),
    .BTN_C(btn[BC]),
    .POS  (POS),
    .ROW  (ROW),
    .COL  (COL),
    .KEY  (KEY),
    .BUSY (BUSY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  row;
    logic [3:0]  col;
    logic [4:0]  pos;
    logic [25:0] key;
    logic        busy;
  } obs_t;

  typedef struct {
    int   cyc;  // negative: arrival cycle not checked
    obs_t o;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  obs_t prev_obs;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int c, input logic [1:0] r, input logic [3:0] col,
                          input logic [4:0] p, input logic [25:0] k, input logic b);
    exp_t e;
    e.cyc = c;
    e.o   = {r, col, p, k, b};
    sb_q.push_back(e);
  endtask

  function automatic obs_t sample_obs();
    return {ROW, COL, POS, KEY, BUSY};
  endfunction

  // Monitor: every change of the observed outputs must match the next entry.
  always @(negedge clk) begin
    obs_t cur;
    exp_t e;
    if (mon_en) begin
      cur = sample_obs();
      if (cur !== prev_obs) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got outputs 0x%0h, expected no change from 0x%0h (cyc=%0d)",
                   cur, prev_obs, cyc);
        end else begin
          e = sb_q.pop_front();
          check("sb_row",  32'(cur.row),  32'(e.o.row));
          check("sb_col",  32'(cur.col),  32'(e.o.col));
          check("sb_pos",  32'(cur.pos),  32'(e.o.pos));
          check("sb_key",  32'(cur.key),  32'(e.o.key));
          check("sb_busy", 32'(cur.busy), 32'(e.o.busy));
          if (e.cyc >= 0) check("sb_latency", cyc, e.cyc);
        end
        prev_obs = cur;
      end
    end
  end

  // Hold one button for 10 cycles and expect one move, 7 cycles after the
  // first sampling edge (drive at cycle K, first sample K+1, update K+8).
  task automatic move(input int b, input logic [1:0] r, input logic [3:0] c, input logic [4:0] p);
    @(negedge clk);
    push_exp(cyc + 8, r, c, p, '0, 1'b0);
    btn[b] = 1'b1;
    repeat (10) @(negedge clk);
    btn[b] = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  initial begin
    int got;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("reset_row",  32'(ROW),  32'd0);
    check("reset_col",  32'(COL),  32'd0);
    check("reset_pos",  32'(POS),  32'd20);
    check("reset_key",  32'(KEY),  32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    prev_obs = sample_obs();
    mon_en   = 1'b1;

    // Short glitch on R: no event expected.
    @(negedge clk);
    btn[BR] = 1'b1;
    repeat (3) @(negedge clk);
    btn[BR] = 1'b0;
    repeat (12) @(negedge clk);

    move(BR, 2'd0, 4'd1, 5'd21);
    move(BL, 2'd0, 4'd0, 5'd20);
    move(BL, 2'd0, 4'd7, 5'd18);  // row 0 wraps over 0..7
    move(BR, 2'd0, 4'd0, 5'd20);
    move(BD, 2'd1, 4'd0, 5'd10);
    move(BL, 2'd1, 4'd8, 5'd4);
    move(BU, 2'd2, 4'd8, 5'd24);  // column 8 skips row 0
    move(BR, 2'd2, 4'd0, 5'd25);

    // Select at (2,0): one-cycle KEY bit16, R while C held is ignored.
    @(negedge clk);
    push_exp(cyc + 8, 2'd2, 4'd0, 5'd25, 26'h0010000, 1'b1);
    push_exp(cyc + 9, 2'd2, 4'd0, 5'd25, 26'h0000000, 1'b1);
    btn[BC] = 1'b1;
    repeat (12) @(negedge clk);
    btn[BR] = 1'b1;
    repeat (10) @(negedge clk);
    btn[BR] = 1'b0;
    repeat (14) @(negedge clk);
    push_exp(cyc + 7, 2'd2, 4'd0, 5'd25, 26'h0000000, 1'b0);
    btn[BC] = 1'b0;
    repeat (14) @(negedge clk);
    move(BR, 2'd2, 4'd1, 5'd9);

    move(BU, 2'd1, 4'd1, 5'd11);
    move(BL, 2'd1, 4'd0, 5'd10);

    // U and L together from (1,0): only U acts.
    @(negedge clk);
    push_exp(cyc + 8, 2'd0, 4'd0, 5'd20, '0, 1'b0);
    btn[BU] = 1'b1;
    btn[BL] = 1'b1;
    repeat (10) @(negedge clk);
    btn[BU] = 1'b0;
    btn[BL] = 1'b0;
    repeat (14) @(negedge clk);

    // Reset during FIRE, with C held through reset release.
    @(negedge clk);
    push_exp(cyc + 8, 2'd0, 4'd0, 5'd20, 26'h0000001, 1'b1);
    btn[BC] = 1'b1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (KEY !== '0) begin
        got = 1;
        break;
      end
    end
    check("fire_seen", got, 32'd1);
    push_exp(-1, 2'd0, 4'd0, 5'd20, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_key",  32'(KEY),  32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_pos",  32'(POS),  32'd20);
    repeat (2) @(negedge clk);
    push_exp(-1, 2'd0, 4'd0, 5'd20, 26'h0000001, 1'b1);
    push_exp(-1, 2'd0, 4'd0, 5'd20, 26'h0000000, 1'b1);
    #2 rst = 1'b0;
    repeat (14) @(negedge clk);
    push_exp(-1, 2'd0, 4'd0, 5'd20, '0, 1'b0);
    btn[BC] = 1'b0;
    repeat (14) @(negedge clk);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
